// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch unit: walks a program counter, issues one fetch request
//   at a time to the memory controller, and buffers returned words together
//   with their PCs in a small FIFO for the decode stage. A flush redirects the
//   PC and empties the queue. A flush that arrives while a request is in
//   flight waits out that request and drops its data, because the memory
//   controller cannot abort a request once it has been issued.
//
// Ports
//   clk       in   1   clock, all state updates on the rising edge
//   rst       in   1   synchronous active-high reset
//   rdy       in   1   global enable, low freezes all state
//   mc_req    out  1   fetch request to the memory controller
//   mc_addr   out  32  fetch address, valid while mc_req=1
//   mc_flag   in   1   one-cycle pulse, mc_inst valid for the open request
//   mc_inst   in   32  fetched instruction word
//   iq_valid  out  1   queue head is valid
//   iq_inst   out  32  queue-head instruction
//   iq_pc     out  32  queue-head PC
//   iq_ready  in   1   decode accepts the head
//   flush     in   1   redirect request
//   flush_pc  in   32  redirect target
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        mc_req,
    output logic [31:0] mc_addr,
    input  logic        mc_flag,
    input  logic [31:0] mc_inst,
    output logic        iq_valid,
    output logic [31:0] iq_inst,
    output logic [31:0] iq_pc,
    input  logic        iq_ready,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t        r_state;
    logic [31:0]   r_pc;
    logic          r_mc_req;
    logic [31:0]   r_mc_addr;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [31:0]   r_q_inst [IQ_DEPTH];
    logic [31:0]   r_q_pc   [IQ_DEPTH];

    state_t        w_state_nxt;
    logic [31:0]   w_pc_nxt;
    logic          w_req_nxt;
    logic [31:0]   w_addr_nxt;
    logic          w_push;
    logic          w_pop;
    logic          w_clear;
    logic          w_iq_valid;
    logic          w_has_space;

    assign w_iq_valid  = (r_count != {CW{1'b0}});
    assign w_has_space = (r_count < DEPTH_C);

    assign mc_req   = r_mc_req;
    assign mc_addr  = r_mc_addr;
    assign iq_valid = w_iq_valid;
    assign iq_inst  = r_q_inst[r_head];
    assign iq_pc    = r_q_pc[r_head];

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, request outputs, PC update and queue controls
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_req_nxt   = r_mc_req;
        w_addr_nxt  = r_mc_addr;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_clear     = 1'b0;
        if (rdy) begin
            // Flush outranks pop; the FSM below still has to finish any
            // request already handed to memory.
            if (flush) begin
                w_clear  = 1'b1;
                w_pc_nxt = flush_pc;
            end else begin
                w_pop = w_iq_valid & iq_ready;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!flush && w_has_space) begin
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mc_flag) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                        if (!flush) begin
                            w_push   = 1'b1;
                            w_pc_nxt = r_pc + 32'd4;
                        end else begin
                            w_push = 1'b0;
                        end
                    end else if (flush) begin
                        // Request stays on the bus; its data will be dropped.
                        w_state_nxt = ST_DISCARD;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (mc_flag) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end
                default: begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // PC, request registers, queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_mc_req  <= 1'b0;
            r_mc_addr <= 32'h0000_0000;
            r_count   <= {CW{1'b0}};
            r_head    <= {PW{1'b0}};
            r_tail    <= {PW{1'b0}};
        end else begin
            r_pc      <= w_pc_nxt;
            r_mc_req  <= w_req_nxt;
            r_mc_addr <= w_addr_nxt;
            if (w_clear) begin
                r_count <= {CW{1'b0}};
                r_head  <= {PW{1'b0}};
                r_tail  <= {PW{1'b0}};
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_ONE;
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage write port
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_q_inst[r_tail] <= mc_inst;
            r_q_pc[r_tail]   <= r_pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        mc_req;
    logic [31:0] mc_addr;
    logic        mc_flag;
    logic [31:0] mc_inst;
    logic        iq_valid;
    logic [31:0] iq_inst;
    logic [31:0] iq_pc;
    logic        iq_ready;
    logic        flush;
    logic [31:0] flush_pc;

    int n_vec;
    int n_err;

    inst_fetch #(.RESET_PC(32'h0000_0000), .IQ_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .mc_req   (mc_req),
        .mc_addr  (mc_addr),
        .mc_flag  (mc_flag),
        .mc_inst  (mc_inst),
        .iq_valid (iq_valid),
        .iq_inst  (iq_inst),
        .iq_pc    (iq_pc),
        .iq_ready (iq_ready),
        .flush    (flush),
        .flush_pc (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b1;
        rdy      = 1'b0;
        mc_flag  = 1'b0;
        mc_inst  = 32'h0;
        iq_ready = 1'b0;
        flush    = 1'b0;
        flush_pc = 32'h0;

        // Reset wins even with rdy low
        tick();
        tick();
        chk("rst_req", {31'd0, mc_req}, 32'd0);
        chk("rst_addr", mc_addr, 32'h0);
        chk("rst_valid", {31'd0, iq_valid}, 32'd0);

        // Streaming fetch, memory answers two cycles after each request
        rdy      = 1'b1;
        rst      = 1'b0;
        iq_ready = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("s_req", {31'd0, mc_req}, 32'd1);
            chk("s_addr", mc_addr, 32'(4 * k));
            tick();
            chk("s_hold", mc_addr, 32'(4 * k));
            mc_flag = 1'b1;
            mc_inst = 32'h0000_0013;
            tick();
            mc_flag = 1'b0;
            chk("s_req_lo", {31'd0, mc_req}, 32'd0);
            chk("s_valid", {31'd0, iq_valid}, 32'd1);
            chk("s_pc", iq_pc, 32'(4 * k));
            chk("s_inst", iq_inst, 32'h0000_0013);
            tick();
            chk("s_popped", {31'd0, iq_valid}, 32'd0);
        end

        // Reset mid-WAIT abandons the request
        rst      = 1'b1;
        iq_ready = 1'b0;
        tick();
        chk("rst2_req", {31'd0, mc_req}, 32'd0);
        chk("rst2_addr", mc_addr, 32'h0);
        // Stale mc_flag right after reset is ignored
        rst     = 1'b0;
        mc_flag = 1'b1;
        mc_inst = 32'hBAD0_BAD0;
        tick();
        mc_flag = 1'b0;
        chk("stale_valid", {31'd0, iq_valid}, 32'd0);
        chk("stale_req", {31'd0, mc_req}, 32'd1);

        // Fill the queue with decode stalled
        for (int k = 0; k < 4; k++) begin
            chk("f_addr", mc_addr, 32'(4 * k));
            tick();
            mc_flag = 1'b1;
            mc_inst = 32'hA000_0000 + 32'(k);
            tick();
            mc_flag = 1'b0;
            chk("f_req_lo", {31'd0, mc_req}, 32'd0);
            tick();
            chk("f_req_next", {31'd0, mc_req}, (k < 3) ? 32'd1 : 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full_noreq", {31'd0, mc_req}, 32'd0);
        end
        chk("full_head_pc", iq_pc, 32'h0);
        chk("full_head_inst", iq_inst, 32'hA000_0000);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        chk("pop1_pc", iq_pc, 32'h4);
        chk("pop1_inst", iq_inst, 32'hA000_0001);
        chk("pop1_noreq", {31'd0, mc_req}, 32'd0);
        tick();
        chk("refill_req", {31'd0, mc_req}, 32'd1);
        chk("refill_addr", mc_addr, 32'h10);

        // Flush while waiting: request held, data dropped
        flush    = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush = 1'b0;
        chk("fw_valid", {31'd0, iq_valid}, 32'd0);
        chk("fw_req", {31'd0, mc_req}, 32'd1);
        chk("fw_addr", mc_addr, 32'h10);
        tick();
        chk("fw_addr2", mc_addr, 32'h10);
        mc_flag = 1'b1;
        mc_inst = 32'hDEAD_BEEF;
        tick();
        mc_flag = 1'b0;
        chk("fw_drop_req", {31'd0, mc_req}, 32'd0);
        chk("fw_drop_valid", {31'd0, iq_valid}, 32'd0);
        tick();
        chk("fw_new_addr", mc_addr, 32'h100);
        chk("fw_new_req", {31'd0, mc_req}, 32'd1);

        // rdy low freezes everything and ignores mc_flag/flush/iq_ready
        tick();
        rdy      = 1'b0;
        mc_flag  = 1'b1;
        mc_inst  = 32'h7777_7777;
        flush    = 1'b1;
        flush_pc = 32'h300;
        iq_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("frz_req", {31'd0, mc_req}, 32'd1);
            chk("frz_addr", mc_addr, 32'h100);
            chk("frz_valid", {31'd0, iq_valid}, 32'd0);
        end
        rdy      = 1'b1;
        mc_flag  = 1'b0;
        flush    = 1'b0;
        iq_ready = 1'b0;
        tick();
        chk("thaw_addr", mc_addr, 32'h100);
        mc_flag = 1'b1;
        mc_inst = 32'h0000_0011;
        tick();
        mc_flag = 1'b0;
        chk("thaw_valid", {31'd0, iq_valid}, 32'd1);
        chk("thaw_pc", iq_pc, 32'h100);
        chk("thaw_inst", iq_inst, 32'h0000_0011);

        // Flush in the same cycle as mc_flag
        tick();
        chk("ff_addr", mc_addr, 32'h104);
        flush    = 1'b1;
        flush_pc = 32'h200;
        mc_flag  = 1'b1;
        mc_inst  = 32'h0000_0055;
        tick();
        flush   = 1'b0;
        mc_flag = 1'b0;
        chk("ff_req", {31'd0, mc_req}, 32'd0);
        chk("ff_valid", {31'd0, iq_valid}, 32'd0);
        tick();
        chk("ff_new_addr", mc_addr, 32'h200);

        // Build count=2, then push and pop together
        tick();
        mc_flag = 1'b1;
        mc_inst = 32'h0000_00B0;
        tick();
        mc_flag = 1'b0;
        tick();
        mc_flag = 1'b1;
        mc_inst = 32'h0000_00B1;
        tick();
        mc_flag = 1'b0;
        tick();
        chk("pp_addr", mc_addr, 32'h208);
        mc_flag  = 1'b1;
        mc_inst  = 32'h0000_00B2;
        iq_ready = 1'b1;
        tick();
        mc_flag  = 1'b0;
        iq_ready = 1'b0;
        chk("pp_pc", iq_pc, 32'h204);
        chk("pp_inst", iq_inst, 32'h0000_00B1);
        iq_ready = 1'b1;
        tick();
        iq_ready = 1'b0;
        chk("pp_pc2", iq_pc, 32'h208);
        chk("pp_inst2", iq_inst, 32'h0000_00B2);
        iq_ready = 1'b1;
        tick();
        chk("pp_empty", {31'd0, iq_valid}, 32'd0);
        // Pop on an empty queue is ignored
        tick();
        chk("empty_pop", {31'd0, iq_valid}, 32'd0);
        iq_ready = 1'b0;
        mc_flag  = 1'b1;
        mc_inst  = 32'h0000_00C0;
        tick();
        mc_flag = 1'b0;
        chk("ep_valid", {31'd0, iq_valid}, 32'd1);
        chk("ep_pc", iq_pc, 32'h20C);
        chk("ep_inst", iq_inst, 32'h0000_00C0);

        // Flush in IDLE, then PC wrap at the top of the address space
        flush    = 1'b1;
        flush_pc = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        chk("fi_req", {31'd0, mc_req}, 32'd0);
        chk("fi_valid", {31'd0, iq_valid}, 32'd0);
        tick();
        chk("fi_addr", mc_addr, 32'hFFFF_FFFC);
        tick();
        mc_flag = 1'b1;
        mc_inst = 32'h0000_00EE;
        tick();
        mc_flag = 1'b0;
        chk("wrap_pc", iq_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", iq_inst, 32'h0000_00EE);
        tick();
        chk("wrap_req", {31'd0, mc_req}, 32'd1);
        chk("wrap_addr", mc_addr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
